// File: rtl/watch_timekeeper_pkg.sv
// Shared watch constants, mode encodings and key press events.
// The alarm block imports the same definitions.
package watch_pkg;

    localparam logic [7:0] SEC_MAX  = 8'd59;
    localparam logic [7:0] MIN_MAX  = 8'd59;
    localparam logic [7:0] HOUR_MAX = 8'd23;

    typedef enum logic [1:0] {
        MODE_TIME = 2'd0,
        MODE_TSET = 2'd1,
        MODE_ASET = 2'd3
    } mode_e;

    typedef enum logic [1:0] {
        EV_NONE,
        EV_SHORT,
        EV_LONG
    } press_e;

    function automatic logic [7:0] wrap_inc(input logic [7:0] v, input logic [7:0] mx);
        return (v == mx) ? 8'd0 : v + 8'd1;
    endfunction

endpackage

// File: rtl/watch_timekeeper_if.sv
// Time-of-day bus driven by the timekeeper and read by the alarm and display blocks.
interface watch_timekeeper_if;
    logic [7:0] hour;
    logic [7:0] min;
    logic [7:0] sec;
    logic       tick_1hz;
    logic       sel;
    logic       setting;

    modport master (output hour, min, sec, tick_1hz, sel, setting);
    modport slave  (input  hour, min, sec, tick_1hz, sel, setting);
endinterface

// File: rtl/watch_timekeeper_key_press_detector.sv
// One board key: 2-flop synchronizer, debounce, then short/long press classification.
module key_press_detector
    import watch_pkg::*;
#(
    parameter int DEBOUNCE   = 500000,
    parameter int LONG_PRESS = 100000000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_key_n,
    output logic o_short_pulse,
    output logic o_long_pulse
);
    localparam int DW = $clog2(DEBOUNCE + 1);
    localparam int HW = $clog2(LONG_PRESS + 1);

    typedef enum logic [1:0] {S_IDLE, S_HELD, S_LONG} state_e;

    state_e        r_state, w_next;
    logic [1:0]    r_sync;
    logic          r_db;
    logic [DW-1:0] r_db_cnt;
    logic [HW-1:0] r_hold_cnt;
    press_e        w_ev;
    logic          w_pressed;

    // Keys idle high, so the synchronizer and debounced level reset to released.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync   <= 2'b11;
            r_db     <= 1'b1;
            r_db_cnt <= '0;
        end else begin
            r_sync <= {r_sync[0], i_key_n};
            if (r_sync[1] == r_db) begin
                r_db_cnt <= '0;
            end else if (r_db_cnt == DW'(DEBOUNCE - 1)) begin
                r_db     <= r_sync[1];
                r_db_cnt <= '0;
            end else begin
                r_db_cnt <= r_db_cnt + DW'(1);
            end
        end
    end

    assign w_pressed = ~r_db;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_hold_cnt <= '0;
        end else begin
            r_state    <= w_next;
            r_hold_cnt <= (r_state == S_HELD) ? r_hold_cnt + HW'(1) : '0;
        end
    end

    always_comb begin
        w_next = r_state;
        w_ev   = EV_NONE;
        case (r_state)
            S_IDLE: if (w_pressed) w_next = S_HELD;
            S_HELD: begin
                if (!w_pressed) begin
                    w_next = S_IDLE;
                    w_ev   = EV_SHORT;
                end else if (r_hold_cnt == HW'(LONG_PRESS - 1)) begin
                    w_next = S_LONG;
                    w_ev   = EV_LONG;
                end
            end
            S_LONG: if (!w_pressed) w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    assign o_short_pulse = (w_ev == EV_SHORT);
    assign o_long_pulse  = (w_ev == EV_LONG);

endmodule

// File: rtl/watch_timekeeper.sv
// Watch time-of-day: 1 Hz prescaler, h/m/s counters and key-driven time setting.
module watch_timekeeper
    import watch_pkg::*;
#(
    parameter int         CLK_FREQ   = 50000000,
    parameter int         LONG_PRESS = 100000000,
    parameter int         DEBOUNCE   = 500000,
    parameter logic [1:0] SET_MODE   = MODE_TSET
) (
    input  logic               CLOCK_50,
    input  logic               reset,
    input  logic [1:0]         KEY,
    input  logic [1:0]         mode,
    watch_timekeeper_if.master tk
);
    localparam int PW = $clog2(CLK_FREQ + 1);

    logic [PW-1:0] r_presc;
    logic [7:0]    r_hour, r_min, r_sec;
    logic          r_tick, r_sel;
    logic          w_setting;
    logic [1:0]    w_short, w_long;

    for (genvar k = 0; k < 2; k++) begin : g_key
        key_press_detector #(
            .DEBOUNCE  (DEBOUNCE),
            .LONG_PRESS(LONG_PRESS)
        ) u_det (
            .clk          (CLOCK_50),
            .reset        (reset),
            .i_key_n      (KEY[k]),
            .o_short_pulse(w_short[k]),
            .o_long_pulse (w_long[k])
        );
    end

    assign w_setting = (mode == SET_MODE);

    // Ticks only run outside set mode and key pulses only act inside it,
    // so the two update paths are mutually exclusive. KEY[0] outranks KEY[1].
    always_ff @(posedge CLOCK_50) begin
        if (reset) begin
            r_presc <= '0;
            r_hour  <= '0;
            r_min   <= '0;
            r_sec   <= '0;
            r_tick  <= 1'b0;
            r_sel   <= 1'b0;
        end else begin
            r_tick <= 1'b0;
            if (!w_setting) begin
                if (r_presc == PW'(CLK_FREQ - 1)) begin
                    r_presc <= '0;
                    r_tick  <= 1'b1;
                    r_sec   <= wrap_inc(r_sec, SEC_MAX);
                    if (r_sec == SEC_MAX) begin
                        r_min <= wrap_inc(r_min, MIN_MAX);
                        if (r_min == MIN_MAX) r_hour <= wrap_inc(r_hour, HOUR_MAX);
                    end
                end else begin
                    r_presc <= r_presc + PW'(1);
                end
            end else if (w_short[0]) begin
                r_sec   <= '0;
                r_presc <= '0;
            end else if (w_long[0]) begin
                r_hour <= '0;
                r_min  <= '0;
                r_sec  <= '0;
            end else if (w_short[1]) begin
                if (r_sel) r_hour <= wrap_inc(r_hour, HOUR_MAX);
                else       r_min  <= wrap_inc(r_min, MIN_MAX);
            end else if (w_long[1]) begin
                r_sel <= ~r_sel;
            end
        end
    end

    assign tk.hour     = r_hour;
    assign tk.min      = r_min;
    assign tk.sec      = r_sec;
    assign tk.tick_1hz = r_tick;
    assign tk.sel      = r_sel;
    assign tk.setting  = w_setting;

endmodule

// File: tb/tb_watch_timekeeper.sv
// Directed bench for watch_timekeeper with a queued-expectation scoreboard.
module tb_watch_timekeeper;
    localparam int CF = 10;

    logic       CLOCK_50 = 1'b0;
    logic       reset    = 1'b1;
    logic [1:0] KEY      = 2'b11;
    logic [1:0] mode     = 2'd0;

    watch_timekeeper_if tk();

    watch_timekeeper #(
        .CLK_FREQ  (CF),
        .LONG_PRESS(20),
        .DEBOUNCE  (2),
        .SET_MODE  (2'd1)
    ) dut (
        .CLOCK_50(CLOCK_50),
        .reset   (reset),
        .KEY     (KEY),
        .mode    (mode),
        .tk      (tk)
    );

    always #5 CLOCK_50 = ~CLOCK_50;

    typedef struct {
        string       tag;
        logic [31:0] val;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   n_ticks = 0;
    int   m_hour  = 0;
    int   m_min   = 0;
    int   m_sec   = 0;
    int   m_sel   = 0;

    always @(negedge CLOCK_50) if (tk.tick_1hz === 1'b1) n_ticks++;

    task automatic step(input int n);
        repeat (n) @(posedge CLOCK_50);
        #1;
    endtask

    task automatic want(input string tag, input logic [31:0] v);
        sb.push_back('{tag, v});
    endtask

    task automatic check(input logic [31:0] obs);
        exp_t e;
        n_tests++;
        if (sb.size() == 0) begin
            n_fail++;
            $error("FAIL scoreboard_empty: got %0d, no expectation queued", obs);
            return;
        end
        e = sb.pop_front();
        assert (obs === e.val) else begin
            n_fail++;
            $error("FAIL %s: got %0d, expected %0d", e.tag, obs, e.val);
        end
    endtask

    task automatic want_state(input string tag, input bit with_sec);
        want({tag, ".hour"}, m_hour);
        want({tag, ".min"}, m_min);
        if (with_sec) want({tag, ".sec"}, m_sec);
        want({tag, ".sel"}, m_sel);
    endtask

    task automatic check_state(input bit with_sec);
        check(tk.hour);
        check(tk.min);
        if (with_sec) check(tk.sec);
        check(tk.sel);
    endtask

    // mask bit = 1 holds that key low for 'hold' cycles, then settles.
    task automatic press(input logic [1:0] mask, input int hold);
        KEY = ~mask;
        step(hold);
        KEY = 2'b11;
        step(8);
    endtask

    task automatic k1_short_set(input string tag);
        if (m_sel != 0) m_hour = (m_hour + 1) % 24;
        else            m_min  = (m_min + 1) % 60;
        want_state(tag, 1'b1);
        press(2'b10, 5);
        check_state(1'b1);
    endtask

    task automatic k1_long_set(input string tag);
        want({tag, ".sel_mid_hold"}, m_sel);
        KEY = 2'b01;
        step(15);
        check(tk.sel);
        m_sel = 1 - m_sel;
        want({tag, ".sel_late_hold"}, m_sel);
        step(15);
        check(tk.sel);
        KEY = 2'b11;
        step(8);
        want_state(tag, 1'b1);
        check_state(1'b1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected bench to finish");
        $fatal(1);
    end

    initial begin
        int t_at;
        int t_cnt;
        int snap;

        step(3);
        reset = 1'b0;
        want("rst.hour", 0);    check(tk.hour);
        want("rst.min", 0);     check(tk.min);
        want("rst.sec", 0);     check(tk.sec);
        want("rst.tick", 0);    check(tk.tick_1hz);
        want("rst.sel", 0);     check(tk.sel);
        want("rst.setting", 0); check(tk.setting);

        // first second
        t_at  = 0;
        t_cnt = 0;
        for (int i = 1; i <= CF; i++) begin
            step(1);
            if (tk.tick_1hz === 1'b1) begin
                t_cnt++;
                t_at = i;
                want("t1.sec_at_tick", 1);
                check(tk.sec);
            end
        end
        want("t1.tick_count", 1);  check(t_cnt);
        want("t1.tick_cycle", CF); check(t_at);
        m_sec = 1;
        want_state("t1", 1'b1);
        check_state(1'b1);
        step(1);
        want("t1.tick_low", 0); check(tk.tick_1hz);

        // set mode: minute wraps without carry, then sel toggle and hour setting
        mode = 2'd1;
        snap = n_ticks;
        want("set.setting", 1); check(tk.setting);
        for (int i = 0; i < 60; i++) k1_short_set("t3.min_inc");
        k1_long_set("t4.sel_to_hour");
        for (int i = 0; i < 23; i++) k1_short_set("t4.hour_inc");
        k1_long_set("t4.sel_to_min");
        for (int i = 0; i < 59; i++) k1_short_set("t2.min_to_59");

        // both keys together: KEY[0] clears seconds, KEY[1] minute step dropped
        m_sec = 0;
        want_state("both_keys", 1'b1);
        press(2'b11, 5);
        check_state(1'b1);
        want("set.no_ticks", snap); check(n_ticks);

        // run to 23:59:59 and across midnight
        mode = 2'd0;
        step(59 * CF);
        want("t2.hour_59s", 23); check(tk.hour);
        want("t2.min_59s", 59);  check(tk.min);
        want("t2.sec_59s", 59);  check(tk.sec);
        want("t2.tick_59s", 1);  check(tk.tick_1hz);
        step(CF);
        m_hour = 0;
        m_min  = 0;
        m_sec  = 0;
        want("t2.hour_wrap", 0); check(tk.hour);
        want("t2.min_wrap", 0);  check(tk.min);
        want("t2.sec_wrap", 0);  check(tk.sec);
        want("t2.tick_wrap", 1); check(tk.tick_1hz);

        // pulses outside set mode are discarded
        want_state("t5.mode0_short", 1'b0);
        press(2'b10, 5);
        check_state(1'b0);
        mode = 2'd1;
        KEY  = 2'b01;
        step(8);
        mode = 2'd0;
        step(2);
        KEY = 2'b11;
        step(8);
        want_state("t5.mode_switch", 1'b0);
        check_state(1'b0);

        // reset in the middle of a long hold
        mode = 2'd1;
        m_sec = 0;
        press(2'b01, 5);
        k1_long_set("t6.sel_to_hour");
        k1_short_set("t6.hour_inc");
        KEY = 2'b01;
        step(12);
        reset = 1'b1;
        step(2);
        want("t6.rst_hour", 0); check(tk.hour);
        want("t6.rst_min", 0);  check(tk.min);
        want("t6.rst_sec", 0);  check(tk.sec);
        want("t6.rst_tick", 0); check(tk.tick_1hz);
        want("t6.rst_sel", 0);  check(tk.sel);
        reset  = 1'b0;
        m_hour = 0;
        m_min  = 0;
        m_sec  = 0;
        m_sel  = 1;
        step(45);
        want("t6.sel_one_long", 1); check(tk.sel);
        KEY = 2'b11;
        step(8);
        want_state("t6.after_release", 1'b1);
        check_state(1'b1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
